led_panel_scan: RTL and testbench
=================================

Name: led_panel_scan

Overview:
- Reads the 64x64 monochrome pong frame out of the renderer and drives a HUB75-style 1/32-scan LED panel.
- Each row pass shifts two rows out serially: upper row y on r1, lower row y+32 on r2.
- Then latches them, selects the row address and enables the outputs for a fixed on-time.
- Sits between the game renderer (pixel source) and the panel pins; it is the consumer of the frame the renderer produces.

Parameters:
- COLS, 64, columns shifted per row pass.
- ROW_AW, 5, row-address width; 2**ROW_AW row pairs per frame.
- CLK_DIV, 2, clk cycles per panel_clk phase (low and high); legal range >=2.
- LAT_CYCLES, 1, cycles panel_lat is held high.
- ON_CYCLES, 64, cycles panel_oe_n is held low per row.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scan enable.
- pix_rd_en  out  1  one-cycle pixel read strobe.
- pix_x  out  6  column being read.
- pix_row  out  ROW_AW  row pair being read.
- pix_top  in  1  pixel (pix_x, pix_row); valid the cycle after pix_rd_en.
- pix_bot  in  1  pixel (pix_x, pix_row+32); valid the cycle after pix_rd_en.
- panel_clk  out  1  panel shift clock.
- panel_r1  out  1  upper-half data.
- panel_r2  out  1  lower-half data.
- panel_lat  out  1  panel latch.
- panel_oe_n  out  1  panel output enable, active low.
- panel_addr  out  ROW_AW  displayed row pair.
- frame_start  out  1  one-cycle pulse at start of row-0 shift.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous on rst_n low, released synchronously to clk): all outputs 0 except panel_oe_n=1.
- Reset also clears row counter and column counter to 0 and puts the FSM in IDLE.
- FSM states: IDLE -> SHIFT -> BLANK -> LATCH -> DISPLAY -> (SHIFT | IDLE).
- IDLE:
  - panel_oe_n=1.
  - When enable=1, go to SHIFT with row counter=0 and assert frame_start for the first SHIFT cycle.
- SHIFT, for each column c = 0..COLS-1:
  - Low phase = CLK_DIV cycles with panel_clk=0.
  - In the first low-phase cycle, pix_rd_en=1, pix_x=c, pix_row=row.
  - In the second low-phase cycle, panel_r1/panel_r2 register pix_top/pix_bot.
  - High phase = CLK_DIV cycles with panel_clk=1; data held stable.
  - After the last high phase of column COLS-1, go to BLANK, panel_clk=0.
  - Shift length is COLS*2*CLK_DIV cycles.
- pix_rd_en is never asserted outside SHIFT. pix_x/pix_row hold their last value when not reading.
- BLANK: 1 cycle, panel_oe_n=1, panel_addr <= row.
- LATCH: panel_lat=1 for LAT_CYCLES, panel_oe_n=1.
- DISPLAY:
  - panel_oe_n=0 for ON_CYCLES.
  - On exit, row wraps 31 -> 0 (modulo 2**ROW_AW).
  - If enable=1, go to SHIFT; frame_start pulses if the new row is 0.
  - If enable=0, go to IDLE.
- enable is sampled only in IDLE and on the last DISPLAY cycle. Deassertion mid-row completes that row (shift, latch, display) before IDLE.
- Row period with defaults: 256+1+1+64 = 322 cycles. Frame = 32*322 = 10304 cycles.
- panel_oe_n is never low in SHIFT, BLANK or LATCH. panel_lat and panel_oe_n=0 are never simultaneous.
- panel_addr changes only in BLANK.
- Reset asserted mid-operation: outputs return to reset values immediately; the next scan starts at row 0 with frame_start.

Test Plan:
- Reset, enable=0 for 1000 cycles -> all outputs at reset values; panel_oe_n=1, busy=0, no pix_rd_en.
- enable=1, source returns pix_top=1 only for (x=5,row=0), pix_bot=1 only for (x=63,row=0) -> exactly 64 panel_clk rises before the first panel_lat.
  - panel_r1=1 only at rise 6.
  - panel_r2=1 only at rise 64.
  - frame_start pulses once at the first SHIFT cycle.
- Default parameters, free run -> consecutive panel_lat rises 322 cycles apart.
  - panel_oe_n low exactly 64 cycles per row.
  - panel_addr increments 0,1,...,31,0.
  - frame_start every 10304 cycles.
- Drop enable in row 7 SHIFT -> row 7 still latched and displayed (panel_addr=7, 64 cycles oe_n low); then IDLE, busy=0, panel_oe_n=1.
- rst_n low during row 3 DISPLAY -> panel_oe_n=1 and panel_addr=0 without a clk edge.
  - After release with enable=1: frame_start, and pix_row=0 on the first read.
- CLK_DIV=3 -> panel_clk period 6 cycles.
  - pix_rd_en spacing 6 cycles.
  - Row period 384+1+1+64 = 450 cycles.

Source files
------------

// File: rtl/led_panel_scan.sv
// led_panel_scan
// ----------------------------------------------------------------------------
// Scans the 64x64 monochrome frame held by the renderer onto a HUB75-style
// 1/32-scan LED panel. Every row pass reads row pair (y, y+32) column by
// column, shifts the two bits out on panel_r1/panel_r2 with a divided shift
// clock, blanks, latches, points panel_addr at the new row and lights it for
// a fixed on-time.
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   enable           scan enable (sampled in IDLE and on the last DISPLAY cycle)
//   pix_rd_en        one-cycle read strobe towards the renderer
//   pix_x, pix_row   column / row pair being read
//   pix_top, pix_bot pixel data, valid the cycle after pix_rd_en
//   panel_clk        panel shift clock
//   panel_r1/r2      upper / lower half serial data
//   panel_lat        panel latch
//   panel_oe_n       panel output enable, active low
//   panel_addr       row pair currently displayed
//   frame_start      one-cycle pulse on the first shift cycle of row 0
//   busy             high whenever the scanner is not idle
// ----------------------------------------------------------------------------
module led_panel_scan #(
    parameter int COLS       = 64,
    parameter int ROW_AW     = 5,
    parameter int CLK_DIV    = 2,
    parameter int LAT_CYCLES = 1,
    parameter int ON_CYCLES  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              pix_rd_en,
    output logic [5:0]        pix_x,
    output logic [ROW_AW-1:0] pix_row,
    input  logic              pix_top,
    input  logic              pix_bot,
    output logic              panel_clk,
    output logic              panel_r1,
    output logic              panel_r2,
    output logic              panel_lat,
    output logic              panel_oe_n,
    output logic [ROW_AW-1:0] panel_addr,
    output logic              frame_start,
    output logic              busy
);

    // Phase counter spans one full panel_clk period: CLK_DIV low then CLK_DIV high.
    localparam int PH_W    = $clog2(2 * CLK_DIV);
    localparam int CNT_MAX = (ON_CYCLES > LAT_CYCLES) ? ON_CYCLES : LAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_HIGH  = PH_W'(CLK_DIV);
    localparam logic [PH_W-1:0]  PH_READ  = PH_W'(0);
    localparam logic [PH_W-1:0]  PH_CAP   = PH_W'(1);
    localparam logic [5:0]       LAST_COL = 6'(COLS - 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_AW-1:0]  row_q, row_d;
    logic [5:0]         col_q, col_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ROW_AW-1:0]  addr_q, addr_d;
    logic               r1_q, r1_d;
    logic               r2_q, r2_d;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            phase_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            r1_q    <= 1'b0;
            r2_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
        end
    end

    // Next-state logic. The column counter is left on the last column after a
    // shift and the row counter is only advanced when another row follows, so
    // pix_x/pix_row (driven straight from them) change only on a read cycle.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        r1_d    = r1_q;
        r2_d    = r2_q;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SHIFT;
                    row_d   = '0;
                    col_d   = '0;
                    phase_d = '0;
                end
            end

            SHIFT: begin
                // Renderer answers the read one cycle later; capture it then.
                if (phase_q == PH_CAP) begin
                    r1_d = pix_top;
                    r2_d = pix_bot;
                end
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (col_q == LAST_COL) begin
                        state_d = BLANK;
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            BLANK: begin
                addr_d  = row_q;
                cnt_d   = '0;
                state_d = LATCH;
            end

            LATCH: begin
                if (cnt_q == LAT_LAST) begin
                    cnt_d   = '0;
                    state_d = DISPLAY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DISPLAY: begin
                if (cnt_q == ON_LAST) begin
                    cnt_d = '0;
                    if (enable) begin
                        state_d = SHIFT;
                        row_d   = row_q + 1'b1;
                        col_d   = '0;
                        phase_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Panel and pixel-bus outputs decode directly from registered state, so an
    // asynchronous reset forces them to their idle values immediately.
    assign pix_rd_en   = (state_q == SHIFT) && (phase_q == PH_READ);
    assign pix_x       = col_q;
    assign pix_row     = row_q;
    assign panel_clk   = (state_q == SHIFT) && (phase_q >= PH_HIGH);
    assign panel_r1    = r1_q;
    assign panel_r2    = r2_q;
    assign panel_lat   = (state_q == LATCH);
    assign panel_oe_n  = (state_q != DISPLAY);
    assign panel_addr  = addr_q;
    assign frame_start = (state_q == SHIFT) && (row_q == '0) && (col_q == 6'd0)
                         && (phase_q == PH_READ);
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_led_panel_scan.sv
// tb_led_panel_scan
// ----------------------------------------------------------------------------
// Directed bench for led_panel_scan. One instance runs with default parameters
// and a tiny pixel-source model; a second instance runs with CLK_DIV=3 to
// check the stretched timing.
// ----------------------------------------------------------------------------
module tb_led_panel_scan;

    logic       clk = 1'b0;
    logic       rstN;
    logic       enable;
    logic       enableB;

    logic       pixRdEn;
    logic [5:0] pixX;
    logic [4:0] pixRow;
    logic       pixTop = 1'b0;
    logic       pixBot = 1'b0;
    logic       panelClk, panelR1, panelR2, panelLat, panelOeN;
    logic [4:0] panelAddr;
    logic       frameStart, busy;

    logic       pixRdEnB;
    logic [5:0] pixXB;
    logic [4:0] pixRowB;
    logic       pixTopB = 1'b0;
    logic       pixBotB = 1'b0;
    logic       panelClkB, panelR1B, panelR2B, panelLatB, panelOeNB;
    logic [4:0] panelAddrB;
    logic       frameStartB, busyB;

    int assertCount = 0;
    int failCount   = 0;

    int cycle = 0;
    int riseCnt = 0, r1Ones = 0, r1Idx = 0, r2Ones = 0, r2Idx = 0;
    int rdTotal = 0, busyCnt = 0, oeLowTotal = 0, invBad = 0;
    int oeCnt = 0;
    bit rowStarted = 0;
    logic prevClk = 1'b0, prevLat = 1'b0, prevClkB = 1'b0, prevLatB = 1'b0;
    int latTimes[$];
    int latAddr[$];
    int oeLow[$];
    int fsTimes[$];
    int rdB[$];
    int riseB[$];
    int latB[$];

    led_panel_scan dut (
        .clk(clk), .rst_n(rstN), .enable(enable),
        .pix_rd_en(pixRdEn), .pix_x(pixX), .pix_row(pixRow),
        .pix_top(pixTop), .pix_bot(pixBot),
        .panel_clk(panelClk), .panel_r1(panelR1), .panel_r2(panelR2),
        .panel_lat(panelLat), .panel_oe_n(panelOeN), .panel_addr(panelAddr),
        .frame_start(frameStart), .busy(busy)
    );

    led_panel_scan #(.CLK_DIV(3)) dutB (
        .clk(clk), .rst_n(rstN), .enable(enableB),
        .pix_rd_en(pixRdEnB), .pix_x(pixXB), .pix_row(pixRowB),
        .pix_top(pixTopB), .pix_bot(pixBotB),
        .panel_clk(panelClkB), .panel_r1(panelR1B), .panel_r2(panelR2B),
        .panel_lat(panelLatB), .panel_oe_n(panelOeNB), .panel_addr(panelAddrB),
        .frame_start(frameStartB), .busy(busyB)
    );

    always #5 clk = ~clk;

    // Pixel source: top lit only at (5,0), bottom only at (63,0); one-cycle read latency.
    always @(posedge clk) begin
        if (pixRdEn) begin
            pixTop <= (pixX == 6'd5)  && (pixRow == 5'd0);
            pixBot <= (pixX == 6'd63) && (pixRow == 5'd0);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rstVal, input logic enVal);
        rstN    = rstVal;
        enable  = enVal;
        enableB = enVal;
    endtask

    // Advance to the next falling edge and gather statistics from both instances.
    task automatic tick();
        @(negedge clk);
        cycle++;
        if (pixRdEn) rdTotal++;
        if (busy) busyCnt++;
        if (!panelOeN) oeLowTotal++;
        if (panelClk && !prevClk) begin
            riseCnt++;
            if (panelR1) begin r1Ones++; r1Idx = riseCnt; end
            if (panelR2) begin r2Ones++; r2Idx = riseCnt; end
        end
        prevClk = panelClk;
        if (panelLat && !prevLat) begin
            latTimes.push_back(cycle);
            latAddr.push_back(int'(panelAddr));
            if (rowStarted) oeLow.push_back(oeCnt);
            oeCnt = 0;
            rowStarted = 1;
        end
        prevLat = panelLat;
        if (!panelOeN) oeCnt++;
        if (frameStart) fsTimes.push_back(cycle);
        if (panelLat && !panelOeN) invBad++;
        if (!panelOeN && (panelClk || pixRdEn)) invBad++;
        if (pixRdEnB && rdB.size() < 3) rdB.push_back(cycle);
        if (panelClkB && !prevClkB && riseB.size() < 2) riseB.push_back(cycle);
        prevClkB = panelClkB;
        if (panelLatB && !prevLatB && latB.size() < 2) latB.push_back(cycle);
        prevLatB = panelLatB;
    endtask

    initial begin
        int bad;
        int idx;
        int snapRd;
        bit found;

        // Reset and idle behaviour
        applyStimulus(1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("rst_ctrl", {pixRdEn, panelClk, panelR1, panelR2, panelLat,
                                 panelOeN, frameStart, busy}, 32'h04);
        checkOutput("rst_addr", {pixX, pixRow, panelAddr}, 32'd0);
        applyStimulus(1'b1, 1'b0);
        rdTotal = 0; busyCnt = 0; oeLowTotal = 0;
        repeat (1000) tick();
        checkOutput("idle_rd_en", rdTotal, 0);
        checkOutput("idle_busy", busyCnt, 0);
        checkOutput("idle_oe_low", oeLowTotal, 0);
        checkOutput("idle_oe_n", panelOeN, 1);

        // First row: shift contents and frame_start
        applyStimulus(1'b1, 1'b1);
        riseCnt = 0; r1Ones = 0; r2Ones = 0; r1Idx = 0; r2Idx = 0;
        tick();
        checkOutput("first_fs", frameStart, 1);
        checkOutput("first_rd", {pixRdEn, pixX, pixRow}, {1'b1, 6'd0, 5'd0});
        checkOutput("first_busy", busy, 1);
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            if (latTimes.size() > 0) found = 1;
        end
        checkOutput("lat1_seen", found, 1);
        checkOutput("rises_before_lat", riseCnt, 64);
        checkOutput("r1_ones", r1Ones, 1);
        checkOutput("r1_rise_idx", r1Idx, 6);
        checkOutput("r2_ones", r2Ones, 1);
        checkOutput("r2_rise_idx", r2Idx, 64);
        checkOutput("fs_count_row0", fsTimes.size(), 1);
        checkOutput("lat1_addr", latAddr[0], 0);

        // Free run over a full frame
        found = 0;
        for (int i = 0; i < 12000 && !found; i++) begin
            tick();
            if (latTimes.size() >= 33 && fsTimes.size() >= 2) found = 1;
        end
        checkOutput("frame_seen", found, 1);
        if (found) begin
            checkOutput("lat_period", latTimes[1] - latTimes[0], 322);
            bad = 0;
            for (int i = 1; i < 33; i++) begin
                if (latTimes[i] - latTimes[i-1] != 322) bad++;
                if (latAddr[i] != (i % 32)) bad++;
            end
            checkOutput("lat_seq_bad", bad, 0);
            checkOutput("addr_wrap", latAddr[32], 0);
            checkOutput("addr_31", latAddr[31], 31);
            bad = 0;
            for (int i = 0; i < oeLow.size(); i++) if (oeLow[i] != 64) bad++;
            checkOutput("oe_low_rows", oeLow.size() >= 32, 1);
            checkOutput("oe_low_bad", bad, 0);
            checkOutput("frame_period", fsTimes[1] - fsTimes[0], 10304);
        end
        checkOutput("b_rd_seen", rdB.size(), 3);
        checkOutput("b_rd_space", (rdB.size() >= 2) ? rdB[1] - rdB[0] : -1, 6);
        checkOutput("b_rd_space2", (rdB.size() >= 3) ? rdB[2] - rdB[1] : -1, 6);
        checkOutput("b_clk_period", (riseB.size() >= 2) ? riseB[1] - riseB[0] : -1, 6);
        checkOutput("b_row_period", (latB.size() >= 2) ? latB[1] - latB[0] : -1, 450);

        // Drop enable during row 7 shift
        found = 0;
        for (int i = 0; i < 12000 && !found; i++) begin
            tick();
            if (pixRdEn && pixRow == 5'd7) found = 1;
        end
        checkOutput("row7_seen", found, 1);
        applyStimulus(1'b1, 1'b0);
        idx = latTimes.size();
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            tick();
            if (latTimes.size() > idx) found = 1;
        end
        checkOutput("row7_lat_seen", found, 1);
        if (found) checkOutput("row7_addr", latAddr[idx], 7);
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            if (!busy) found = 1;
        end
        checkOutput("row7_idle_seen", found, 1);
        checkOutput("row7_oe_low", oeCnt, 64);
        checkOutput("row7_oe_n", panelOeN, 1);
        snapRd = rdTotal;
        repeat (50) tick();
        checkOutput("row7_no_rd", rdTotal - snapRd, 0);
        checkOutput("row7_busy", busy, 0);

        // Asynchronous reset during row 3 display
        applyStimulus(1'b1, 1'b1);
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick();
            if (!panelOeN && panelAddr == 5'd3) found = 1;
        end
        checkOutput("row3_disp_seen", found, 1);
        repeat (10) tick();
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("arst_oe_n", panelOeN, 1);
        checkOutput("arst_addr", panelAddr, 0);
        checkOutput("arst_busy", busy, 0);
        repeat (2) tick();
        applyStimulus(1'b1, 1'b1);
        tick();
        checkOutput("rel_fs", frameStart, 1);
        checkOutput("rel_rd", {pixRdEn, pixRow}, {1'b1, 5'd0});

        checkOutput("invariants", invBad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
